// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_pkg
// Purpose  : Shared types and constants for the two-port RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    // Default RAM geometry: 256 words of 8 bits
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    // Port indices as they appear on gnt_id / winner
    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    // Sequencer states: one sampling cycle, one RAM cycle, one ack cycle
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick2
// Purpose  : Combinational two-way winner selection, round-robin or fixed
//            priority (port 0 first).
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       fixed_prio,
    output logic       valid,
    output logic       winner
);

    // A tie goes to port 0 under fixed priority, otherwise to the port
    // that did not win last time; a lone request always wins.
    always_comb begin
        valid  = |req;
        winner = P0;
        if (req == 2'b11) begin
            winner = fixed_prio ? P0 : ~last_grant;
        end else if (req[1]) begin
            winner = P1;
        end
    end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Arbitrates two req/ack requesters onto a single-port RAM with
//            combinational read data. Each access takes IDLE -> ACCESS ->
//            RESP, with a one-cycle ack in RESP.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,

    output logic              busy,
    output logic              gnt_id,

    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    arb_state_t r_state;
    logic       r_we;
    logic       r_last_grant;
    logic       w_valid;
    logic       w_winner;

    rr_pick2 u_pick (
        .req        ({req1, req0}),
        .last_grant (r_last_grant),
        .fixed_prio (FIXED_PRIO != 0),
        .valid      (w_valid),
        .winner     (w_winner)
    );

    // Write strobe exists only in ACCESS; an async reset drops it at once
    // because the state register clears without waiting for a clock.
    assign ram_rw = (r_state == ACCESS) && r_we;

    // Sequencer: latch the winner's command, run one RAM cycle, then ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_last_grant <= P1;
            busy         <= 1'b0;
            gnt_id       <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            rdata0       <= '0;
            rdata1       <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_state      <= ACCESS;
                        busy         <= 1'b1;
                        gnt_id       <= w_winner;
                        r_last_grant <= w_winner;
                        r_we         <= (w_winner == P1) ? we1    : we0;
                        ram_addr     <= (w_winner == P1) ? addr1  : addr0;
                        ram_wdata    <= (w_winner == P1) ? wdata1 : wdata0;
                    end
                end
                ACCESS: begin
                    r_state <= RESP;
                    if (!r_we) begin
                        if (gnt_id == P1) begin
                            rdata1 <= ram_rdata;
                        end else begin
                            rdata0 <= ram_rdata;
                        end
                    end
                    ack0 <= (gnt_id == P0);
                    ack1 <= (gnt_id == P1);
                end
                RESP: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : ram_arbiter
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Self-checking bench for ram_arbiter (round-robin and fixed
//            priority instances) against a transaction-level reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Round-robin instance signals
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       ack0, ack1, busy, gnt_id, ram_rw;
    logic [7:0] rdata0, rdata1, ram_addr, ram_wdata, ram_rdata;
    logic [7:0] ram_mem [256];

    // Fixed-priority instance signals
    logic       f_req0, f_we0, f_req1, f_we1;
    logic [7:0] f_addr0, f_wdata0, f_addr1, f_wdata1;
    logic       f_ack0, f_ack1, f_busy, f_gnt_id, f_ram_rw;
    logic [7:0] f_rdata0, f_rdata1, f_ram_addr, f_ram_wdata, f_ram_rdata;
    logic [7:0] f_ram_mem [256];

    ram_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(0)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .busy(busy), .gnt_id(gnt_id), .ram_rw(ram_rw), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    ram_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1)) u_fix (
        .clk(clk), .rst(rst),
        .req0(f_req0), .we0(f_we0), .addr0(f_addr0), .wdata0(f_wdata0), .ack0(f_ack0), .rdata0(f_rdata0),
        .req1(f_req1), .we1(f_we1), .addr1(f_addr1), .wdata1(f_wdata1), .ack1(f_ack1), .rdata1(f_rdata1),
        .busy(f_busy), .gnt_id(f_gnt_id), .ram_rw(f_ram_rw), .ram_addr(f_ram_addr),
        .ram_wdata(f_ram_wdata), .ram_rdata(f_ram_rdata)
    );

    // Behavioural single-port RAMs: combinational read, clocked write
    always @(posedge clk) if (ram_rw) ram_mem[ram_addr] <= ram_wdata;
    always @(posedge clk) if (f_ram_rw) f_ram_mem[f_ram_addr] <= f_ram_wdata;
    assign ram_rdata   = ram_mem[ram_addr];
    assign f_ram_rdata = f_ram_mem[f_ram_addr];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Transaction-level reference: an access granted at edge k executes at
    // edge k+1, acks in the following cycle and frees the RAM at edge k+3.
    int         cyc;
    int         free_edge;
    int         acc_edge;
    int         rw_cnt;
    bit         last_g;
    bit         acc_port;
    bit         acc_we;
    logic [7:0] acc_addr, acc_wdata, exp_addr, exp_wdata;
    logic [7:0] exp_rd0, exp_rd1;
    logic [7:0] ref_mem [256];

    task automatic model_reset();
        last_g    = 1'b1;
        exp_rd0   = 8'h00;
        exp_rd1   = 8'h00;
        exp_addr  = 8'h00;
        exp_wdata = 8'h00;
        acc_edge  = -10;
        free_edge = cyc + 1;
    endtask

    task automatic compare_cycle();
        bit eb;
        eb = (cyc == acc_edge) || (cyc == acc_edge + 1);
        check("busy",      busy,      eb);
        check("ack0",      ack0,      (cyc == acc_edge + 1) && !acc_port);
        check("ack1",      ack1,      (cyc == acc_edge + 1) && acc_port);
        check("ram_rw",    ram_rw,    (cyc == acc_edge) && acc_we);
        check("rdata0",    rdata0,    exp_rd0);
        check("rdata1",    rdata1,    exp_rd1);
        check("ram_addr",  ram_addr,  exp_addr);
        check("ram_wdata", ram_wdata, exp_wdata);
        if (eb) check("gnt_id", gnt_id, acc_port);
    endtask

    // Advance one clock, update the reference with the inputs seen at the
    // edge, then compare every observable output.
    task automatic step();
        bit         sr, sq0, sq1, sw0, sw1, w;
        logic [7:0] sa0, sa1, sd0, sd1;
        sr = rst;  sq0 = req0; sq1 = req1; sw0 = we0; sw1 = we1;
        sa0 = addr0; sa1 = addr1; sd0 = wdata0; sd1 = wdata1;
        @(posedge clk);
        #1;
        cyc++;
        if (ram_rw) rw_cnt++;
        if (sr) begin
            model_reset();
        end else begin
            if (cyc == acc_edge + 1) begin
                if (acc_we) ref_mem[acc_addr] = acc_wdata;
                else if (acc_port) exp_rd1 = ref_mem[acc_addr];
                else exp_rd0 = ref_mem[acc_addr];
            end
            if (cyc >= free_edge && (sq0 || sq1)) begin
                if (sq0 && sq1) w = !last_g;
                else w = sq1;
                last_g    = w;
                acc_port  = w;
                acc_edge  = cyc;
                free_edge = cyc + 3;
                acc_we    = w ? sw1 : sw0;
                acc_addr  = w ? sa1 : sa0;
                acc_wdata = w ? sd1 : sd0;
                exp_addr  = acc_addr;
                exp_wdata = acc_wdata;
            end
        end
        if (!rst) compare_cycle();
    endtask

    task automatic set_port(input bit p, input bit r, input bit w, input logic [7:0] a, input logic [7:0] d);
        if (p) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    endtask

    // Single access from an idle arbiter; returns cycles to ack and rdata.
    task automatic do_access(input bit p, input bit w, input logic [7:0] a, input logic [7:0] d,
                             output int lat, output logic [7:0] rd);
        bit got;
        got = 1'b0;
        lat = 0;
        set_port(p, 1'b1, w, a, d);
        for (int i = 0; i < 8 && !got; i++) begin
            step();
            lat++;
            if (p ? ack1 : ack0) got = 1'b1;
        end
        check("access_timeout", got, 1'b1);
        rd = p ? rdata1 : rdata0;
        set_port(p, 1'b0, w, a, d);
        step();
    endtask

    initial begin
        int         lat;
        logic [7:0] rd, snap1;
        int         q_port[$];
        logic [7:0] q_data[$];
        int         ack_cyc[$];
        int         n0, n1;
        bit         got;

        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        f_req0 = 0; f_we0 = 0; f_addr0 = 0; f_wdata0 = 0;
        f_req1 = 0; f_we1 = 0; f_addr1 = 0; f_wdata1 = 0;
        cyc = 0; rw_cnt = 0;
        model_reset();
        for (int i = 0; i < 256; i++) begin
            ram_mem[i]   = 8'(i ^ 8'h5A);
            ref_mem[i]   = 8'(i ^ 8'h5A);
            f_ram_mem[i] = 8'(i ^ 8'h5A);
        end
        ram_mem[1] = 8'h11; ref_mem[1] = 8'h11; f_ram_mem[1] = 8'h11;
        ram_mem[2] = 8'h22; ref_mem[2] = 8'h22; f_ram_mem[2] = 8'h22;
        ram_mem[8'h10] = 8'h33; ref_mem[8'h10] = 8'h33;

        // Reset state
        rst = 1'b1;
        step();
        step();
        check("rst_busy", busy, 1'b0);
        check("rst_ack0", ack0, 1'b0);
        check("rst_ack1", ack1, 1'b0);
        check("rst_gnt", gnt_id, 1'b0);
        check("rst_rw", ram_rw, 1'b0);
        check("rst_addr", ram_addr, 8'h00);
        check("rst_rdata0", rdata0, 8'h00);
        check("rst_f_busy", f_busy, 1'b0);
        rst = 1'b0;
        step();

        // Single write then read on port 0
        rw_cnt = 0;
        do_access(1'b0, 1'b1, 8'h20, 8'h5C, lat, rd);
        check("wr_latency", lat, 2);
        do_access(1'b0, 1'b0, 8'h20, 8'h00, lat, rd);
        check("rd_latency", lat, 2);
        check("rd_data", rd, 8'h5C);
        check("rw_cycles", rw_cnt, 1);

        // Round-robin from reset: both ports held continuously
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_port(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
        set_port(1'b1, 1'b1, 1'b0, 8'h02, 8'h00);
        for (int i = 0; i < 12; i++) begin
            step();
            if (ack0) begin q_port.push_back(0); q_data.push_back(rdata0); end
            if (ack1) begin q_port.push_back(1); q_data.push_back(rdata1); end
        end
        set_port(1'b0, 1'b0, 1'b0, 8'h01, 8'h00);
        set_port(1'b1, 1'b0, 1'b0, 8'h02, 8'h00);
        check("rr_count", q_port.size(), 4);
        for (int i = 0; i < q_port.size() && i < 4; i++) begin
            check("rr_order", q_port[i], i % 2);
            check("rr_data", q_data[i], (i % 2 == 0) ? 8'h11 : 8'h22);
        end
        repeat (3) step();

        // Write/read race with port 0 granted last
        do_access(1'b0, 1'b0, 8'h05, 8'h00, lat, rd);
        snap1 = rdata1;
        q_port.delete();
        set_port(1'b1, 1'b1, 1'b1, 8'h30, 8'hF0);
        set_port(1'b0, 1'b1, 1'b0, 8'h30, 8'h00);
        rd = 8'h00;
        for (int i = 0; i < 12 && q_port.size() < 2; i++) begin
            step();
            if (ack1) begin q_port.push_back(1); req1 = 1'b0; end
            if (ack0) begin q_port.push_back(0); rd = rdata0; req0 = 1'b0; end
        end
        check("race_count", q_port.size(), 2);
        if (q_port.size() > 0) check("race_first", q_port[0], 1);
        check("race_rdata0", rd, 8'hF0);
        check("race_rdata1", rdata1, snap1);
        repeat (2) step();

        // Held req0: back-to-back reads, rdata1 untouched
        snap1 = rdata1;
        set_port(1'b0, 1'b1, 1'b0, 8'h20, 8'h00);
        for (int i = 0; i < 7; i++) begin
            step();
            if (ack0) begin ack_cyc.push_back(cyc); check("held_rdata0", rdata0, 8'h5C); end
        end
        req0 = 1'b0;
        check("held_count", ack_cyc.size(), 2);
        if (ack_cyc.size() == 2) check("held_spacing", ack_cyc[1] - ack_cyc[0], 3);
        check("held_rdata1", rdata1, snap1);
        repeat (5) step();

        // Asynchronous reset in the middle of a write
        set_port(1'b0, 1'b1, 1'b1, 8'h10, 8'hAA);
        step();
        check("mid_rw_before", ram_rw, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rw", ram_rw, 1'b0);
        check("mid_busy", busy, 1'b0);
        check("mid_ack0", ack0, 1'b0);
        check("mid_gnt", gnt_id, 1'b0);
        check("mid_addr", ram_addr, 8'h00);
        check("mid_wdata", ram_wdata, 8'h00);
        check("mid_rdata0", rdata0, 8'h00);
        check("mid_rdata1", rdata1, 8'h00);
        req0 = 1'b0;
        step();
        rst = 1'b0;
        check("mid_ram_kept", ram_mem[8'h10], 8'h33);
        step();

        // Fixed priority: port 1 starves while port 0 holds its request
        f_req0 = 1'b1; f_addr0 = 8'h01;
        f_req1 = 1'b1; f_addr1 = 8'h02;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (f_ack0) n0++;
            if (f_ack1) n1++;
        end
        check("fix_ack0_count", n0, 5);
        check("fix_ack1_count", n1, 0);
        check("fix_rdata0", f_rdata0, 8'h11);
        f_req0 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 3 && !got; i++) begin
            step();
            if (f_ack1) got = 1'b1;
        end
        check("fix_ack1_after_drop", got, 1'b1);
        check("fix_rdata1", f_rdata1, 8'h22);
        f_req1 = 1'b0;
        repeat (2) step();

        // Randomized traffic from two independent requesters
        for (int i = 0; i < 1500; i++) begin
            step();
            if (ack0) begin
                if ($urandom_range(3) != 0) req0 = 1'b0;
            end else if (!req0 && $urandom_range(2) == 0) begin
                set_port(1'b0, 1'b1, 1'($urandom_range(1)), 8'($urandom_range(7)), 8'($urandom));
            end
            if (ack1) begin
                if ($urandom_range(3) != 0) req1 = 1'b0;
            end else if (!req1 && $urandom_range(2) == 0) begin
                set_port(1'b1, 1'b1, 1'($urandom_range(1)), 8'($urandom_range(7)), 8'($urandom));
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ram_arbiter
`default_nettype wire

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and sequencer for the single-port 256x8 data RAM. Two requesters share the RAM: port 0 (CPU core) and port 1 (I/O or loader engine). Each gets a simple req/ack handshake. The arbiter picks one request at a time, drives the RAM's RW/address/write-data inputs from registers, captures combinational read data, and returns it with a one-cycle ack.

## Interface
Parameters:
- ADDR_W, default 8: RAM address width (256 words).
- DATA_W, default 8: RAM word width.
- FIXED_PRIO, default 0: 0 = round-robin; 1 = port 0 always wins.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0  in  1  port 0 access request; held until ack0.
- we0  in  1  port 0: 1 = write, 0 = read; stable while req0.
- addr0  in  ADDR_W  port 0 address; stable while req0.
- wdata0  in  DATA_W  port 0 write data; stable while req0.
- ack0  out  1  port 0 one-cycle completion pulse.
- rdata0  out  DATA_W  port 0 read data; valid while ack0=1.
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- busy  out  1  1 whenever state is not IDLE.
- gnt_id  out  1  port currently owning the RAM; meaningful when busy=1.
- ram_rw  out  1  to RAM write enable (1 = write at next clk edge).
- ram_addr  out  ADDR_W  to RAM address.
- ram_wdata  out  DATA_W  to RAM write data.
- ram_rdata  in  DATA_W  from RAM combinational read data.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:**
  - No request: stay in IDLE.
  - Any request: pick a winner.
  - On the edge, latch the winner's we/addr/wdata into the RAM-side registers, set gnt_id, and go to ACCESS.
- **ACCESS (exactly 1 cycle):**
  - ram_rw = latched we.
  - At the edge leaving ACCESS:
    - a write commits in the RAM;
    - a read captures ram_rdata into the winner's rdata register.
  - Then go to RESP.
- **RESP (exactly 1 cycle):**
  - ack of gnt_id = 1; the other ack = 0. Then go to IDLE.
- ram_rw is 0 in IDLE and RESP, so no write can happen outside ACCESS.
- ram_addr and ram_wdata hold their last values outside ACCESS.
- Arbitration, round-robin (FIXED_PRIO=0):
  - Both requesting: grant goes to the port not granted last.
  - last_grant resets to 1, so port 0 wins the first tie.
  - last_grant updates on every grant.
- Arbitration, fixed priority (FIXED_PRIO=1): port 0 wins whenever req0=1.
- A loser keeps its req asserted and is served next. No request is dropped.
- rdataN holds its value until that port's next read completes. Writes leave rdataN unchanged.
- Requester rules:
  - Deassert req in the cycle ack is seen.
  - If req is still 1 when IDLE samples it, that is a new access.
- Reset (any time, including mid-ACCESS):
  - State returns to IDLE immediately.
  - ram_rw, ack0, ack1, busy, gnt_id, ram_addr, ram_wdata, rdata0, rdata1 all go to 0.
  - last_grant goes to 1.
  - A write in flight is aborted: ram_rw drops before the edge.

## Timing
- req sampled in IDLE at edge N → ACCESS during cycle N..N+1 → data written or captured at edge N+1 → ack high during cycle N+1..N+2 → IDLE after edge N+2.
- Latency is 2 cycles from the sampling edge to ack. Peak throughput is 1 access per 3 cycles.
- Back-to-back, both ports requesting continuously: grants alternate 0,1,0,1 and each port gets 1 access per 6 cycles.
- req rising during ACCESS or RESP is not sampled until the next IDLE cycle.
- All outputs are registered except ram_rw, which is decoded from state plus the latched we. It is glitch-free relative to clk.

## Structure
- Package ram_arb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - defaults for ADDR_W and DATA_W;
  - port-index constants P0=0 and P1=1.
- Sub-module rr_pick2:
  - inputs: req[1:0], last_grant, fixed_prio;
  - outputs: valid, winner;
  - purely combinational.
- The top level holds the FSM, RAM-side registers, rdata registers and ack generation. It connects directly to the RAM's RW, address, data-out and data-in buses.

## Test plan
- **Reset:** assert rst mid-ACCESS with we0=1, addr0=0x10, wdata0=0xAA → ram_rw falls immediately, all outputs are 0, and RAM[0x10] is unchanged.
- **Single write then read:** port 0 writes 0x5C to 0x20; later port 0 reads 0x20.
  - ack0 occurs 2 cycles after the sampling edge for each access.
  - The read returns rdata0=0x5C.
  - ram_rw is high exactly 1 cycle in total.
- **Simultaneous requests, round-robin:**
  - port 0 reads 0x01 (preloaded 0x11); port 1 reads 0x02 (preloaded 0x22); both held continuously.
  - Port 0 gets ack first (0x11), port 1 next (0x22).
  - Grants then keep alternating.
- **FIXED_PRIO=1:** req0 held continuously with req1 also high → port 1 never acks. Drop req0 → port 1 acks within 3 cycles.
- **Write/read race:** port 1 writes 0xF0 to 0x30 while port 0 requests a read of 0x30 in the same cycle (last_grant=0) → port 1 is served first and port 0 reads 0xF0.
- **Held req:** port 0 keeps req0 high after ack0 → a second access starts at the next IDLE sample; rdata1 is unaffected.
